div_result_reconstructor: RTL and testbench
===========================================

Name: div_result_reconstructor

Overview:
- Inverse-direction companion to the approximate array dividers (`n`/`d` → `q`/`r`).
- Takes a divider result (`q`, `r`) with its divisor `d` and the original dividend `n_ref`.
- Rebuilds `n_rec = q*d + r` with a sequential shift-and-add datapath, then reports the signed reconstruction error.
- Accumulates absolute-error statistics on-chip, used by the heuristic characterisation flow to score approximate divider variants without an external reference model.

Parameters:
- W, 8, width of `q`, `d` and `r`; the dividend is 2*W bits wide.
- ACC_W, 32, width of the absolute-error accumulator.
- CNT_W, 16, width of the sample counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept an operand set
- q  in  W  quotient under test
- d  in  W  divisor
- r  in  W  remainder under test
- n_ref  in  2*W  original dividend
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- n_rec  out  2*W  reconstructed dividend, q*d+r
- err  out  2*W+1  signed, n_ref - n_rec
- exact  out  1  1 when n_rec == n_ref
- acc_clr  in  1  synchronous clear of statistics
- abs_err_sum  out  ACC_W  saturating sum of |err|
- sample_cnt  out  CNT_W  saturating count of completed results

Behaviour:
- One clock; reset is asynchronous and active-low (`rst_n`). Nothing else in the block is asynchronous.
- Reset values:
  - State IDLE; `in_ready` = 1.
  - `out_valid`, `n_rec`, `err`, `exact`, `abs_err_sum` and `sample_cnt` all 0.
  - Internal operand, partial-product and bit-index registers 0.
- FSM states: IDLE, MUL, ADDR, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`, latch `q`, `d`, `r`, `n_ref`; clear the accumulator; set bit index = 0; go to MUL.
- MUL:
  - `in_ready` = 0.
  - Each cycle: if `q_latched[idx]`, add `d_latched << idx` into the 2*W-bit partial product.
  - `idx` increments each cycle; after `idx` = W-1, go to ADDR.
  - Always exactly W cycles; there is no early exit on zero bits.
- ADDR (one cycle):
  - Partial product += zero-extended `r_latched`, giving `n_rec`.
  - Compute `err` = `n_ref` - `n_rec` as a (2*W+1)-bit two's complement value; `exact` = (`err` == 0).
  - Go to DONE.
- DONE:
  - `out_valid` = 1; `n_rec`, `err` and `exact` stay stable while `out_valid` & !`out_ready`.
  - On `out_valid` & `out_ready`:
    - `abs_err_sum` += |`err|`, saturating at all-ones.
    - `sample_cnt` += 1, saturating at all-ones.
    - Next state IDLE; `out_valid` drops next cycle.
- Latency: accept at cycle T → `out_valid` high at T+W+2 (T+10 for W=8). Minimum initiation interval W+3 cycles.
- Width and overflow:
  - `q*d + r` ≤ (2^W-1)^2 + 2^W-1 < 2^(2W), so `n_rec` never overflows.
  - `err` range is [-(2^(2W)-1), 2^(2W)-1] and fits 2*W+1 bits.
- Boundary cases:
  - `d` = 0: `n_rec` = `r`.
  - `q` = 0: `n_rec` = `r`.
- `acc_clr`:
  - Zeroes `abs_err_sum` and `sample_cnt` on the next edge in any state; it does not disturb the FSM or the result registers.
  - If `acc_clr` coincides with an output handshake, the clear wins and the result is not counted.
- Reset mid-operation: the in-flight operation is dropped and all outputs return to their reset values immediately (asynchronous).
- `in_valid` while busy is ignored. Input values are sampled only at the accept edge; later changes have no effect.

Test Plan:
- Basic: `q`=0x0D, `d`=0x11, `r`=0x05, `n_ref`=0x00E2 → `n_rec`=0x00E2, `err`=0, `exact`=1, `out_valid` at T+10, `sample_cnt`=1, `abs_err_sum`=0.
- Max operands and signed error: `q`=`d`=`r`=0xFF, `n_ref`=0xFFFF → `n_rec`=0xFF00, `err`=+255, `exact`=0. Then `q`=0x10, `d`=0x10, `r`=0x00, `n_ref`=0x00F0 → `n_rec`=0x0100, `err`=-16 (17'h1FFF0); `abs_err_sum`=271.
- Backpressure: hold `out_ready`=0 for 5 cycles → `out_valid` stays 1, outputs stable, `in_ready`=0, no stats update; `out_ready`=1 → exactly one count increment, then `in_ready`=1 the following cycle.
- Reset mid-MUL: deassert `rst_n` at T+4 → all outputs 0 immediately, `in_ready`=1 after release; a new operand set then completes normally.
- Statistics: preload via 3 results with |`err|` = 5, 7, 0 → `abs_err_sum`=12, `sample_cnt`=3. Assert `acc_clr` on the handshake cycle of a 4th result → both 0 afterwards. With ACC_W=8, drive sums past 255 → `abs_err_sum` holds at 0xFF.
- Degenerate: `d`=0, `q`=0xAB, `r`=0x07, `n_ref`=0x0007 → `n_rec`=0x0007, `exact`=1. Toggle `in_valid` and operands during MUL → the result is unaffected.

Source files
------------

// File: rtl/div_result_reconstructor.sv
// div_result_reconstructor: rebuilds n_rec = q*d + r with a serial
// shift-and-add multiplier. It reports the signed error against the
// original dividend and keeps saturating absolute-error statistics.
module div_result_reconstructor #(
  parameter int unsigned W     = 8,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       q,
  input  logic [W-1:0]       d,
  input  logic [W-1:0]       r,
  input  logic [2*W-1:0]     n_ref,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     n_rec,
  output logic [2*W:0]       err,
  output logic               exact,
  input  logic               acc_clr,
  output logic [ACC_W-1:0]   abs_err_sum,
  output logic [CNT_W-1:0]   sample_cnt
);

  localparam int unsigned IDXW = (W > 1) ? $clog2(W) : 1;
  // The sum is kept wide enough for either operand, plus a carry bit.
  localparam int unsigned SW   = ((ACC_W > 2*W) ? ACC_W : 2*W) + 1;
  localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});

  typedef enum logic [1:0] {IDLE, MUL, ADDR, DONE} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      q_lat, d_lat, r_lat;
  logic [2*W-1:0]    nref_lat;
  logic [2*W-1:0]    pp;
  logic [IDXW-1:0]   idx;

  logic              accept, fire, idx_last;
  logic [2*W-1:0]    pp_add;
  logic [2*W-1:0]    n_rec_nxt;
  logic [2*W:0]      err_nxt;
  logic [2*W-1:0]    abs_err;
  logic [SW-1:0]     sum_w;

  // Handshake qualifiers and datapath arithmetic
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    accept    = in_valid & in_ready;
    fire      = out_valid & out_ready;
    idx_last  = (idx == IDXW'(W-1));
    pp_add    = q_lat[idx] ? (pp + ({{W{1'b0}}, d_lat} << idx)) : pp;
    n_rec_nxt = pp + {{W{1'b0}}, r_lat};
    err_nxt   = {1'b0, nref_lat} - {1'b0, n_rec_nxt};
    abs_err   = err[2*W] ? ((~err[2*W-1:0]) + 1'b1) : err[2*W-1:0];
    sum_w     = SW'(abs_err_sum) + SW'(abs_err);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)   state_nxt = MUL;
      MUL:  if (idx_last) state_nxt = ADDR;
      ADDR:               state_nxt = DONE;
      DONE: if (fire)     state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, serial multiply and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_lat    <= '0;
      d_lat    <= '0;
      r_lat    <= '0;
      nref_lat <= '0;
      pp       <= '0;
      idx      <= '0;
      n_rec    <= '0;
      err      <= '0;
      exact    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          q_lat    <= q;
          d_lat    <= d;
          r_lat    <= r;
          nref_lat <= n_ref;
          pp       <= '0;
          idx      <= '0;
        end
        MUL: begin
          pp  <= pp_add;
          idx <= idx + 1'b1;
        end
        ADDR: begin
          n_rec <= n_rec_nxt;
          err   <= err_nxt;
          exact <= (err_nxt == '0);
        end
        default: ;
      endcase
    end
  end

  // Saturating statistics; a clear takes priority over a coincident handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_err_sum <= '0;
      sample_cnt  <= '0;
    end else if (acc_clr) begin
      abs_err_sum <= '0;
      sample_cnt  <= '0;
    end else if (fire) begin
      abs_err_sum <= (sum_w > ACC_MAX) ? '1 : sum_w[ACC_W-1:0];
      if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_div_result_reconstructor.sv
// Directed testbench for div_result_reconstructor.
module tb_div_result_reconstructor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, exact, acc_clr;
  logic [7:0]  q, d, r;
  logic [15:0] n_ref, n_rec;
  logic [16:0] err;
  logic [31:0] abs_err_sum;
  logic [15:0] sample_cnt;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, exact8;
  logic [15:0] n_rec8;
  logic [16:0] err8;
  logic [7:0]  abs_err_sum8;
  logic [15:0] sample_cnt8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_result_reconstructor #(.W(8), .ACC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .d(d), .r(r), .n_ref(n_ref), .out_valid(out_valid),
    .out_ready(out_ready), .n_rec(n_rec), .err(err), .exact(exact),
    .acc_clr(acc_clr), .abs_err_sum(abs_err_sum), .sample_cnt(sample_cnt)
  );

  div_result_reconstructor #(.W(8), .ACC_W(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .q(q), .d(d), .r(r), .n_ref(n_ref), .out_valid(out_valid8),
    .out_ready(out_ready8), .n_rec(n_rec8), .err(err8), .exact(exact8),
    .acc_clr(acc_clr), .abs_err_sum(abs_err_sum8), .sample_cnt(sample_cnt8)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one operand set for a single accept edge
  task automatic start_op(input logic [7:0] qi, di, ri, input logic [15:0] ni);
    q = qi; d = di; r = ri; n_ref = ni;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL wait_done: out_valid=%b required 1 within 40 cycles", out_valid);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, n_rec, err, exact, abs_err_sum, sample_cnt} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: ov=%b n_rec=%h err=%h exact=%b sum=%0d cnt=%0d rdy=%b required zeros/rdy=1",
               out_valid, n_rec, err, exact, abs_err_sum, sample_cnt, in_ready);
    end
  endtask

  task automatic test_basic();
    start_op(8'h0D, 8'h11, 8'h05, 16'h00E2);
    repeat (8) step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: out_valid=%b required 0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid=%b required 1", out_valid); end
    checks++;
    if (n_rec !== 16'h00E2 || err !== 17'h0 || exact !== 1'b1) begin
      errors++; $display("FAIL basic_result: n_rec=%h err=%h exact=%b required 00e2 0 1", n_rec, err, exact);
    end
    handshake();
    checks++;
    if (sample_cnt !== 16'd1 || abs_err_sum !== 32'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_stats: cnt=%0d sum=%0d ov=%b required 1 0 0", sample_cnt, abs_err_sum, out_valid);
    end
  endtask

  task automatic test_max_signed();
    start_op(8'hFF, 8'hFF, 8'hFF, 16'hFFFF);
    wait_done();
    checks++;
    if (n_rec !== 16'hFF00 || err !== 17'd255 || exact !== 1'b0) begin
      errors++; $display("FAIL max_result: n_rec=%h err=%h exact=%b required ff00 000ff 0", n_rec, err, exact);
    end
    handshake();
    start_op(8'h10, 8'h10, 8'h00, 16'h00F0);
    wait_done();
    checks++;
    if (n_rec !== 16'h0100 || err !== 17'h1FFF0 || exact !== 1'b0) begin
      errors++; $display("FAIL neg_result: n_rec=%h err=%h exact=%b required 0100 1fff0 0", n_rec, err, exact);
    end
    handshake();
    checks++;
    if (abs_err_sum !== 32'd271 || sample_cnt !== 16'd3) begin
      errors++; $display("FAIL max_stats: sum=%0d cnt=%0d required 271 3", abs_err_sum, sample_cnt);
    end
  endtask

  task automatic test_back_to_back_backpressure();
    logic [15:0] cnt0;
    cnt0 = sample_cnt;
    start_op(8'h07, 8'h09, 8'h02, 16'h0041);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || n_rec !== 16'h0041 || err !== 17'h0 || in_ready !== 1'b0 || sample_cnt !== cnt0) begin
        errors++;
        $display("FAIL backpressure_hold: ov=%b n_rec=%h err=%h rdy=%b cnt=%0d required 1 0041 0 0 %0d",
                 out_valid, n_rec, err, in_ready, sample_cnt, cnt0);
      end
    end
    handshake();
    checks++;
    if (sample_cnt !== cnt0 + 16'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_release: cnt=%0d rdy=%b ov=%b required %0d 1 0",
                         sample_cnt, in_ready, out_valid, cnt0 + 16'd1);
    end
    step();
    checks++;
    if (sample_cnt !== cnt0 + 16'd1) begin
      errors++; $display("FAIL backpressure_once: cnt=%0d required %0d", sample_cnt, cnt0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid_mul();
    start_op(8'h33, 8'h44, 8'h01, 16'h1234);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, n_rec, err, exact, abs_err_sum, sample_cnt} !== '0) begin
      errors++; $display("FAIL reset_mid: n_rec=%h err=%h sum=%0d cnt=%0d required all 0",
                         n_rec, err, abs_err_sum, sample_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ready: rdy=%b ov=%b required 1 0", in_ready, out_valid);
    end
    start_op(8'h03, 8'h05, 8'h04, 16'h0013);
    wait_done();
    checks++;
    if (n_rec !== 16'h0013 || exact !== 1'b1) begin
      errors++; $display("FAIL reset_mid_after: n_rec=%h exact=%b required 0013 1", n_rec, exact);
    end
    handshake();
    checks++;
    if (sample_cnt !== 16'd1) begin errors++; $display("FAIL reset_mid_cnt: cnt=%0d required 1", sample_cnt); end
  endtask

  task automatic test_statistics();
    acc_clr = 1'b1; step(); acc_clr = 1'b0;
    start_op(8'd1, 8'd10, 8'd0, 16'd15); wait_done(); handshake();
    start_op(8'd2, 8'd3, 8'd1, 16'd0);  wait_done();
    checks++;
    if (err !== 17'h1FFF9) begin errors++; $display("FAIL stats_err7: err=%h required 1fff9", err); end
    handshake();
    start_op(8'd0, 8'd0, 8'd9, 16'd9);  wait_done(); handshake();
    checks++;
    if (abs_err_sum !== 32'd12 || sample_cnt !== 16'd3) begin
      errors++; $display("FAIL stats_sum: sum=%0d cnt=%0d required 12 3", abs_err_sum, sample_cnt);
    end
    start_op(8'd4, 8'd4, 8'd0, 16'd20); wait_done();
    acc_clr = 1'b1; handshake(); acc_clr = 1'b0;
    checks++;
    if (abs_err_sum !== 32'd0 || sample_cnt !== 16'd0 || out_valid !== 1'b0 || n_rec !== 16'd16) begin
      errors++; $display("FAIL stats_clr: sum=%0d cnt=%0d ov=%b n_rec=%h required 0 0 0 0010",
                         abs_err_sum, sample_cnt, out_valid, n_rec);
    end
  endtask

  task automatic test_degenerate();
    start_op(8'hAB, 8'h00, 8'h07, 16'h0007);
    wait_done();
    checks++;
    if (n_rec !== 16'h0007 || exact !== 1'b1) begin
      errors++; $display("FAIL degen_d0: n_rec=%h exact=%b required 0007 1", n_rec, exact);
    end
    handshake();
    start_op(8'h0D, 8'h11, 8'h05, 16'h00E2);
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0];
      q = 8'hF0 + 8'(i); d = 8'h5A; r = 8'hC3; n_ref = 16'hBEEF;
      step();
    end
    in_valid = 1'b0;
    wait_done();
    checks++;
    if (n_rec !== 16'h00E2 || err !== 17'h0 || exact !== 1'b1) begin
      errors++; $display("FAIL degen_toggle: n_rec=%h err=%h exact=%b required 00e2 0 1", n_rec, err, exact);
    end
    handshake();
  endtask

  task automatic op8(input logic [15:0] ni);
    int n = 0;
    q = 8'd0; d = 8'd0; r = 8'd0; n_ref = ni;
    in_valid8 = 1'b1; step(); in_valid8 = 1'b0;
    while (!out_valid8 && n < 40) begin step(); n++; end
    checks++;
    if (out_valid8 !== 1'b1) begin errors++; $display("FAIL sat_wait: out_valid=%b required 1", out_valid8); end
    out_ready8 = 1'b1; step(); out_ready8 = 1'b0;
  endtask

  task automatic test_saturation();
    op8(16'd200);
    checks++;
    if (abs_err_sum8 !== 8'd200) begin errors++; $display("FAIL sat_first: sum=%0d required 200", abs_err_sum8); end
    op8(16'd200);
    checks++;
    if (abs_err_sum8 !== 8'hFF || sample_cnt8 !== 16'd2) begin
      errors++; $display("FAIL sat_hold: sum=%h cnt=%0d required ff 2", abs_err_sum8, sample_cnt8);
    end
    op8(16'd1);
    checks++;
    if (abs_err_sum8 !== 8'hFF) begin errors++; $display("FAIL sat_stay: sum=%h required ff", abs_err_sum8); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    q = '0; d = '0; r = '0; n_ref = '0;
    #1;
    test_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();
    test_basic();
    test_max_signed();
    test_back_to_back_backpressure();
    test_reset_mid_mul();
    test_statistics();
    test_degenerate();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
